// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter: 16-slot RAM time-share (VDG slot 0, loader 4/12, CPU 8) over one sync RAM port; results return 2 clk after issue; E/Q from the slot counter
module ram_slot_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_ena,
  input  logic [ADDR_WIDTH-1:0] vdg_addr,
  output logic [7:0]            vdg_data,
  output logic                  vdg_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  ld_wr,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  ld_busy,
  output logic                  ld_overrun,
  output logic [15:0]           ld_count,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_din,
  input  logic [7:0]            ram_dout,
  output logic [3:0]            slot,
  output logic                  e,
  output logic                  q
);
  localparam logic [1:0] T_NONE = 2'd0, T_VDG = 2'd1, T_CPU = 2'd2, T_LD = 2'd3;
  logic [1:0] tag0, tag1, tag_n;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [7:0] buf_data;
  logic is_vdg, is_cpu, drain, accept;
  assign e = slot[3];
  assign q = slot[3] ^ slot[2];
  always_comb begin
    is_vdg = clk_ena && slot == 4'd0;
    is_cpu = clk_ena && slot == 4'd8 && cpu_req;
    drain = clk_ena && (slot == 4'd4 || slot == 4'd12) && ld_busy;
    accept = ld_wr && (!ld_busy || drain);
    tag_n = is_vdg ? T_VDG : is_cpu ? T_CPU : drain ? T_LD : T_NONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
      tag0 <= T_NONE;
      tag1 <= T_NONE;
      vdg_valid <= 1'b0;
      vdg_data <= '0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      ld_count <= '0;
      ld_busy <= 1'b0;
      ld_overrun <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      slot <= clk_ena ? slot + 4'd1 : slot;
      ram_en <= tag_n != T_NONE;
      ram_we <= (is_cpu && cpu_we) || drain;
      ram_addr <= is_vdg ? vdg_addr : is_cpu ? cpu_addr : drain ? buf_addr : ram_addr;
      ram_din <= is_cpu ? cpu_wdata : drain ? buf_data : ram_din;
      tag0 <= tag_n;
      tag1 <= tag0;
      vdg_valid <= tag1 == T_VDG;
      vdg_data <= tag1 == T_VDG ? ram_dout : vdg_data;
      cpu_ack <= tag1 == T_CPU;
      cpu_rdata <= tag1 == T_CPU ? ram_dout : cpu_rdata;
      ld_count <= ld_count + {15'd0, tag1 == T_LD};
      ld_busy <= accept || (ld_busy && !drain);
      ld_overrun <= ld_overrun || (ld_wr && !accept);
      buf_addr <= accept ? ld_addr : buf_addr;
      buf_data <= accept ? ld_data : buf_data;
    end
  end
endmodule

// File: tb/tb_ram_slot_arbiter.sv
// tb_ram_slot_arbiter: bench with sync RAM, spec-level scoreboard and directed slot scenarios
module tb_ram_slot_arbiter;
  logic clk = 0, reset = 1, clk_ena;
  logic [15:0] vdg_addr = 16'h0400, cpu_addr = 0, ld_addr = 0, ram_addr;
  logic [7:0] vdg_data, cpu_rdata, cpu_wdata = 0, ld_data = 0, ram_din, ram_dout = 0;
  logic vdg_valid, cpu_req = 0, cpu_we = 0, cpu_ack, ld_wr = 0, ld_busy, ld_overrun;
  logic ram_en, ram_we, e, q;
  logic [15:0] ld_count;
  logic [3:0] slot;
  logic [1:0] div = 0;
  bit [7:0] mem [0:65535];
  bit [7:0] mm [0:65535];
  int total = 0, bad = 0, cyc = 0, ticks = 0, cnt;
  bit chk_on = 0;

  ram_slot_arbiter #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena),
    .vdg_addr(vdg_addr), .vdg_data(vdg_data), .vdg_valid(vdg_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_busy(ld_busy), .ld_overrun(ld_overrun), .ld_count(ld_count),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .slot(slot), .e(e), .q(q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;
  assign clk_ena = div == 2'd3;

  always @(posedge clk) if (ram_en) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : mem[ram_addr];
  end

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  typedef struct { int due; int kind; logic [7:0] d; } pend_t;
  pend_t pq[$];
  pend_t p;
  logic m_busy = 0, m_ovr = 0, m_en = 0, m_we = 0, m_vv = 0, m_ack = 0;
  logic [15:0] m_baddr = 0, m_addr = 0, m_count = 0;
  logic [7:0] m_bdata = 0, m_din = 0, m_vd = 0, m_rd = 0;
  int s;

  always @(posedge clk) begin
    cyc++;
    m_en = 0; m_we = 0; m_vv = 0; m_ack = 0;
    if (reset) begin
      ticks = 0; m_busy = 0; m_ovr = 0; m_count = 0; m_addr = 0; m_din = 0;
      m_vd = 0; m_rd = 0; m_baddr = 0; m_bdata = 0;
      pq.delete();
    end else begin
      while (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        if (p.kind == 0) begin m_vv = 1; m_vd = p.d; end
        else if (p.kind == 1) begin m_ack = 1; m_rd = p.d; end
        else m_count++;
      end
      if (clk_ena) begin
        s = ticks % 16;
        if (s == 0) begin
          m_en = 1; m_addr = vdg_addr;
          pq.push_back('{cyc + 2, 0, mm[vdg_addr]});
        end else if (s == 8 && cpu_req) begin
          m_en = 1; m_we = cpu_we; m_addr = cpu_addr; m_din = cpu_wdata;
          if (cpu_we) mm[cpu_addr] = cpu_wdata;
          pq.push_back('{cyc + 2, 1, mm[cpu_addr]});
        end else if ((s == 4 || s == 12) && m_busy) begin
          m_en = 1; m_we = 1; m_addr = m_baddr; m_din = m_bdata;
          mm[m_baddr] = m_bdata; m_busy = 0;
          pq.push_back('{cyc + 2, 2, m_bdata});
        end
        ticks++;
      end
      if (ld_wr) begin
        if (!m_busy) begin m_busy = 1; m_baddr = ld_addr; m_bdata = ld_data; end
        else m_ovr = 1;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("slot", slot, ticks % 16);
    chk("e", e, (ticks % 16) >= 8);
    chk("q", q, (ticks % 16) >= 4 && (ticks % 16) <= 11);
    chk("ram_en", ram_en, m_en);
    chk("ram_we", ram_we, m_we);
    chk("ram_addr", ram_addr, m_addr);
    if (m_we) chk("ram_din", ram_din, m_din);
    chk("vdg_valid", vdg_valid, m_vv);
    chk("vdg_data", vdg_data, m_vd);
    chk("cpu_ack", cpu_ack, m_ack);
    chk("cpu_rdata", cpu_rdata, m_rd);
    chk("ld_busy", ld_busy, m_busy);
    chk("ld_overrun", ld_overrun, m_ovr);
    chk("ld_count", ld_count, m_count);
  end

  task automatic to_slot(input int k);
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (ticks % 16 == k) && clk_ena;
    end
    if (!ok) chk("to_slot_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_slot", slot, 0);
    chk("rst_eq", {e, q}, 0);
    chk("rst_strobes", {ram_en, ram_we, vdg_valid, cpu_ack}, 0);
    chk("rst_data", {ram_addr, ram_din, vdg_data, cpu_rdata}, 0);
    chk("rst_ld", {ld_busy, ld_overrun, ld_count}, 0);
    reset = 0;
  endtask

  initial begin
    mem[16'h0400] = 8'hA5;
    mm[16'h0400] = 8'hA5;
    @(negedge clk);
    chk_on = 1;
    do_reset();
    cnt = 0;
    to_slot(1);
    repeat (64) begin @(negedge clk); cnt += int'(vdg_valid); end
    chk("vdg_per_64clk", cnt, 1);
    to_slot(0);
    @(negedge clk);
    chk("vdg_issue", {ram_en, ram_we, ram_addr}, {2'b10, 16'h0400});
    repeat (2) @(negedge clk);
    chk("vdg_result", {vdg_valid, vdg_data}, {1'b1, 8'hA5});
    @(negedge clk);
    chk("vdg_pulse_1clk", vdg_valid, 0);
    to_slot(8);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h3C;
    @(negedge clk);
    cpu_req = 0; cpu_wdata = 8'h00;
    chk("cpu_wr_issue", {ram_en, ram_we, ram_din}, {2'b11, 8'h3C});
    chk("eq_slot9", {e, q}, 2'b11);
    repeat (2) @(negedge clk);
    chk("cpu_wr_ack", cpu_ack, 1);
    to_slot(8);
    cpu_req = 1; cpu_we = 0;
    @(negedge clk);
    cpu_req = 0; cpu_addr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("cpu_rd", {cpu_ack, cpu_rdata}, {1'b1, 8'h3C});
    to_slot(8);
    @(negedge clk);
    chk("cpu_idle_no_en", ram_en, 0);
    to_slot(4);
    @(negedge clk);
    ld_wr = 1; ld_addr = 16'hC000; ld_data = 8'h7E;
    @(negedge clk);
    ld_wr = 0;
    chk("ld_busy_set", ld_busy, 1);
    ld_wr = 1; ld_addr = 16'hC001; ld_data = 8'h11;
    @(negedge clk);
    ld_wr = 0;
    chk("ld_overrun_set", {ld_overrun, ld_busy}, 2'b11);
    to_slot(12);
    @(negedge clk);
    chk("ld_drain", {ram_en, ram_we, ram_addr, ram_din, ld_busy}, {2'b11, 16'hC000, 8'h7E, 1'b0});
    chk("eq_slot13", {e, q}, 2'b10);
    repeat (2) @(negedge clk);
    chk("ld_count_1", ld_count, 1);
    chk("ram_c000", mem[16'hC000], 8'h7E);
    repeat (64) @(negedge clk);
    chk("ld_count_still_1", ld_count, 1);
    chk("ram_c001_dropped", mem[16'hC001], 0);
    do_reset();
    to_slot(12);
    @(negedge clk);
    ld_wr = 1; ld_addr = 16'hD000; ld_data = 8'h55;
    @(negedge clk);
    ld_wr = 0;
    to_slot(4);
    ld_wr = 1; ld_addr = 16'hD001; ld_data = 8'h66;
    @(negedge clk);
    ld_wr = 0;
    chk("sim_drain_old", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, 16'hD000, 8'h55});
    chk("sim_busy_ovr", {ld_busy, ld_overrun}, 2'b10);
    to_slot(12);
    @(negedge clk);
    chk("sim_drain_new", {ram_addr, ram_din, ld_busy}, {16'hD001, 8'h66, 1'b0});
    repeat (2) @(negedge clk);
    chk("sim_count_2", ld_count, 2);
    chk("ram_d001", mem[16'hD001], 8'h66);
    to_slot(8);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
    @(negedge clk);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_rd", {cpu_ack, cpu_rdata}, {1'b1, 8'h3C});
    to_slot(8);
    cpu_req = 1;
    @(negedge clk);
    cpu_req = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_noack", {cpu_ack, cpu_rdata}, 0);
    chk("rst_mid_slot", slot, 0);
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
